elc_request_scheduler: RTL and testbench
========================================

// Module: elc_request_scheduler
// PURPOSE
//  Upstream stage of the elevator controller (pes_elc). Latches asynchronous call-button
//  presses into a pending set and issues one one-hot target floor at a time on
//  request_floor, picked by a SCAN (elevator) policy relative to the car position.
//  Clears a call when the controller signals complete. Holds off new issues during alerts.
// PARAMETERS
//  FLOORS  8  number of floors; width of every floor vector (bit i = floor i)
// PORTS
//  clk            in   1       system clock; all state changes on rising edge
//  reset          in   1       synchronous, active-high reset
//  call_btn       in   FLOORS  call pulses, any number of bits per cycle
//  cur_floor      in   FLOORS  one-hot car position (from controller out_current_floor)
//  complete       in   1       controller: current target reached (1-cycle pulse)
//  hold           in   1       door/weight alert active (over_time|over_weight); blocks new issue
//  request_floor  out  FLOORS  one-hot target to controller; 0 when none
//  req_valid      out  1       request_floor holds a live target
//  sched_dir      out  1       SCAN sweep direction, 1=up 0=down
//  pending        out  FLOORS  outstanding calls, registered
// BEHAVIOUR
//  Reset (clk edge with reset=1, overrides all): pending=0, request_floor=0, req_valid=0,
//   sched_dir=1, state=IDLE. Reset mid-BUSY drops target and all calls.
//  Pending: each edge pending <= (pending | call_btn) & ~clr; clr = target bit on the
//   complete edge in BUSY, else 0. Call on target floor in that same cycle is dropped.
//  FSM states IDLE, BUSY, SETTLE:
//   IDLE: if pending!=0, !hold, cur_floor one-hot -> register target, req_valid=1, ->BUSY.
//     Else stay; request_floor=0, req_valid=0. Invalid cur_floor (0 or multi-hot) never issues.
//   BUSY: request_floor/req_valid held stable; hold and new calls ignored; call_btn still
//     accumulates. On complete: clear target's pending bit, request_floor=0, req_valid=0, ->SETTLE.
//   SETTLE: one cycle, outputs 0, ->IDLE (gives controller a deasserted request edge).
//  complete in IDLE or SETTLE: ignored.
//  Target selection (combinational from registered pending/cur_floor/sched_dir, used in IDLE):
//   1. pending bit at cur_floor set -> target=cur_floor, dir unchanged.
//   2. dir=1: lowest pending floor above cur_floor; if none, highest below and sched_dir<=0.
//   3. dir=0: highest pending floor below cur_floor; if none, lowest above and sched_dir<=1.
//   sched_dir updates only on the IDLE->BUSY edge.
//  Latency: call_btn at edge n visible in pending after n; target issued at edge n+1 when
//   IDLE and not held. complete->next issue minimum 2 edges (BUSY->SETTLE->IDLE->BUSY).
//  Invariants: request_floor is one-hot iff req_valid=1, else 0; request_floor bit is set in
//   pending while BUSY; sched_dir only changes on a reversal issue.
// TESTING
//  T1 reset: assert reset 2 cycles with call_btn=8'hFF -> pending=0, req_valid=0, sched_dir=1.
//  T2 SCAN up: cur=8'h01, press 8'h24 (floors 2,5) -> issues 8'h04; complete, cur=8'h04 ->
//     after SETTLE issues 8'h20; complete -> pending=0, req_valid=0.
//  T3 reversal: sched_dir=1, cur=8'h40, pending=8'h0A -> issues 8'h08, sched_dir=0; complete,
//     cur=8'h08 -> next issue 8'h02, sched_dir stays 0.
//  T4 hold: pending=8'h10, hold=1 for 5 cycles -> req_valid=0 throughout; hold=0 -> 8'h10 next edge.
//  T5 same-floor/complete race: BUSY on 8'h04, call_btn=8'h04 with complete -> bit 2 cleared;
//     call_btn=8'h80 in same cycle -> pending=8'h80 retained.
//  T6 reset mid-BUSY and bad cur_floor: reset while req_valid=1 -> all outputs 0 next edge;
//     cur_floor=8'h00 or 8'h03 with pending!=0 -> stays IDLE, req_valid=0.

Source files
------------

// File: rtl/elc_request_scheduler.sv
// -----------------------------------------------------------------------------
// elc_request_scheduler
//
// Upstream stage of the elevator controller. Call-button pulses are latched
// into a pending set. One target floor at a time is issued, one-hot, on
// request_floor. The target is chosen by a SCAN (elevator) policy relative to
// the current car position. A call is cleared when the controller reports that
// the target has been reached. No new target is issued while an alert (hold)
// is active.
//
// Ports
//   clk            in   1       system clock, rising edge
//   reset          in   1       synchronous, active-high reset
//   call_btn       in   FLOORS  call pulses, any number of bits per cycle
//   cur_floor      in   FLOORS  one-hot car position
//   complete       in   1       current target reached (1-cycle pulse)
//   hold           in   1       alert active, blocks a new issue
//   request_floor  out  FLOORS  one-hot target, 0 when none
//   req_valid      out  1       request_floor holds a live target
//   sched_dir      out  1       SCAN sweep direction, 1 = up, 0 = down
//   pending        out  FLOORS  outstanding calls
//   state_dbg      out  2       FSM state (0 IDLE, 1 BUSY, 2 SETTLE)
//
// Request handshake: req_valid rises together with a one-hot request_floor.
// Both stay frozen until the controller pulses complete. On the edge that
// samples complete, the request drops to 0. It then stays at 0 for at least
// one full SETTLE cycle before any new target is offered. complete is only
// meaningful while a request is live; at any other time it is ignored.
// -----------------------------------------------------------------------------
module elc_request_scheduler #(
   parameter int FLOORS = 8
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [FLOORS-1:0] call_btn,
   input  logic [FLOORS-1:0] cur_floor,
   input  logic              complete,
   input  logic              hold,
   output logic [FLOORS-1:0] request_floor,
   output logic              req_valid,
   output logic              sched_dir,
   output logic [FLOORS-1:0] pending,
   output logic [1:0]        state_dbg
);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      BUSY   = 2'd1,
      SETTLE = 2'd2
   } state_t;

   state_t state;

   localparam logic [FLOORS-1:0] ONE = FLOORS'(1);

   // Isolate the lowest set bit of a vector (0 if the vector is empty).
   function automatic logic [FLOORS-1:0] lowest_bit(input logic [FLOORS-1:0] v);
      logic [FLOORS-1:0] r;
      r = '0;
      for (int i = FLOORS - 1; i >= 0; i--) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   // Isolate the highest set bit of a vector (0 if the vector is empty).
   function automatic logic [FLOORS-1:0] highest_bit(input logic [FLOORS-1:0] v);
      logic [FLOORS-1:0] r;
      r = '0;
      for (int i = 0; i < FLOORS; i++) begin
         if (v[i]) begin
            r    = '0;
            r[i] = 1'b1;
         end
      end
      return r;
   endfunction

   // ---------------------------------------------------------------------------
   // Target selection, from registered pending / sched_dir and the car position
   // ---------------------------------------------------------------------------
   logic              cur_onehot;
   logic [FLOORS-1:0] mask_le;     // floors at or below the car
   logic [FLOORS-1:0] mask_below;  // floors strictly below the car
   logic [FLOORS-1:0] calls_above;
   logic [FLOORS-1:0] calls_below;
   logic              call_here;
   logic [FLOORS-1:0] sel_target;
   logic              sel_dir;
   logic              issue_ok;
   logic [FLOORS-1:0] clr;

   always_comb begin
      cur_onehot  = (cur_floor != '0) && ((cur_floor & (cur_floor - ONE)) == '0);
      // For a one-hot position these are the usual "below" masks. The shift
      // drops the top bit, so the top floor wraps to all-ones, which is right.
      mask_le     = {cur_floor[FLOORS-2:0], 1'b0} - ONE;
      mask_below  = cur_floor - ONE;
      calls_above = pending & ~mask_le;
      calls_below = pending & mask_below;
      call_here   = |(pending & cur_floor);

      sel_target = '0;
      sel_dir    = sched_dir;
      if (call_here) begin
         sel_target = cur_floor;
      end else if (sched_dir) begin
         if (calls_above != '0) begin
            sel_target = lowest_bit(calls_above);
         end else begin
            sel_target = highest_bit(calls_below);
            sel_dir    = 1'b0;
         end
      end else begin
         if (calls_below != '0) begin
            sel_target = highest_bit(calls_below);
         end else begin
            sel_target = lowest_bit(calls_above);
            sel_dir    = 1'b1;
         end
      end

      issue_ok = (pending != '0) && !hold && cur_onehot;

      // A call on the target floor in the completing cycle is absorbed by the
      // clear: the car is already there.
      clr = '0;
      if (state == BUSY && complete) begin
         clr = request_floor;
      end
   end

   // ---------------------------------------------------------------------------
   // FSM, pending set and registered outputs
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (reset) begin
         state         <= IDLE;
         pending       <= '0;
         request_floor <= '0;
         req_valid     <= 1'b0;
         sched_dir     <= 1'b1;
      end else begin
         pending <= (pending | call_btn) & ~clr;
         case (state)
            IDLE: begin
               if (issue_ok) begin
                  request_floor <= sel_target;
                  req_valid     <= 1'b1;
                  sched_dir     <= sel_dir;
                  state         <= BUSY;
               end else begin
                  request_floor <= '0;
                  req_valid     <= 1'b0;
               end
            end
            BUSY: begin
               if (complete) begin
                  request_floor <= '0;
                  req_valid     <= 1'b0;
                  state         <= SETTLE;
               end
            end
            SETTLE: begin
               request_floor <= '0;
               req_valid     <= 1'b0;
               state         <= IDLE;
            end
            default: begin
               request_floor <= '0;
               req_valid     <= 1'b0;
               state         <= IDLE;
            end
         endcase
      end
   end

   assign state_dbg = state;

   // Invariants on the registered outputs
   always @(posedge clk) begin
      if (!reset) begin
         assert (req_valid ? $onehot(request_floor) : (request_floor == '0))
            else $error("request_floor not consistent with req_valid");
         assert (!(state == BUSY) || ((request_floor & pending) != '0))
            else $error("live target not in pending set");
      end
   end

endmodule

// File: tb/tb_elc_request_scheduler.sv
module tb_elc_request_scheduler;
  localparam int N = 8;

  // ---------------- clock / reset / DUT ----------------
  logic         clk = 1'b0;
  logic         reset;
  logic [N-1:0] call_btn;
  logic [N-1:0] cur_floor;
  logic         complete;
  logic         hold;
  logic [N-1:0] request_floor;
  logic         req_valid;
  logic         sched_dir;
  logic [N-1:0] pending;
  logic [1:0]   state_dbg;

  always #5 clk = ~clk;

  elc_request_scheduler #(.FLOORS(N)) dut (
    .clk           (clk),
    .reset         (reset),
    .call_btn      (call_btn),
    .cur_floor     (cur_floor),
    .complete      (complete),
    .hold          (hold),
    .request_floor (request_floor),
    .req_valid     (req_valid),
    .sched_dir     (sched_dir),
    .pending       (pending),
    .state_dbg     (state_dbg)
  );

  // ---------------- scoreboard ----------------
  int n_vec = 0;
  int n_err = 0;
  logic [N-1:0] exp_q[$];   // targets the model expects to see issued
  logic prev_valid = 1'b0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // ---------------- reference model ----------------
  // Car-level view: a set of called floors, a flag for "serving a target",
  // a one-cycle pause after each service, and the sweep direction.
  logic [N-1:0] m_pend   = '0;
  bit           m_busy   = 0;
  bit           m_settle = 0;
  int           m_tgt    = 0;
  bit           m_dir    = 1;

  task automatic model_step(input logic rst, input logic [N-1:0] call,
                            input logic [N-1:0] cur, input logic cmp, input logic hld);
    logic [N-1:0] nxt;
    int c, t;
    if (rst) begin
      m_pend = '0; m_busy = 0; m_settle = 0; m_dir = 1; m_tgt = 0;
      exp_q.delete();
      return;
    end
    nxt = m_pend | call;
    if (m_busy && cmp) nxt[m_tgt] = 1'b0;
    if (m_busy) begin
      if (cmp) begin m_busy = 0; m_settle = 1; end
    end else if (m_settle) begin
      m_settle = 0;
    end else if (m_pend != 0 && !hld && $countones(cur) == 1) begin
      c = 0;
      for (int f = 0; f < N; f++) if (cur[f]) c = f;
      t = -1;
      if (m_pend[c]) t = c;
      else if (m_dir) begin
        for (int f = c + 1; f < N && t < 0; f++) if (m_pend[f]) t = f;
        if (t < 0) begin
          for (int f = c - 1; f >= 0 && t < 0; f--) if (m_pend[f]) t = f;
          m_dir = 0;
        end
      end else begin
        for (int f = c - 1; f >= 0 && t < 0; f--) if (m_pend[f]) t = f;
        if (t < 0) begin
          for (int f = c + 1; f < N && t < 0; f++) if (m_pend[f]) t = f;
          m_dir = 1;
        end
      end
      m_tgt  = t;
      m_busy = 1;
      exp_q.push_back(N'(1) << t);
    end
    m_pend = nxt;
  endtask

  // ---------------- driver ----------------
  task automatic cycle(input logic rst, input logic [N-1:0] call, input logic [N-1:0] cur,
                       input logic cmp, input logic hld);
    logic [N-1:0] exp_req;
    logic [N-1:0] got_issue;
    reset = rst; call_btn = call; cur_floor = cur; complete = cmp; hold = hld;
    model_step(rst, call, cur, cmp, hld);
    @(posedge clk);
    #1;
    exp_req = m_busy ? (N'(1) << m_tgt) : '0;
    check("pending",       pending,       m_pend);
    check("req_valid",     req_valid,     m_busy);
    check("request_floor", request_floor, exp_req);
    check("sched_dir",     sched_dir,     m_dir);
    if (req_valid && !prev_valid) begin
      if (exp_q.size() == 0) begin
        check("issue_unexpected", request_floor, 0);
      end else begin
        got_issue = exp_q.pop_front();
        check("issue_order", request_floor, got_issue);
      end
    end
    prev_valid = req_valid;
  endtask

  task automatic idle(input logic [N-1:0] cur, input int n);
    for (int i = 0; i < n; i++) cycle(0, '0, cur, 0, 0);
  endtask

  // ---------------- stimulus ----------------
  logic [N-1:0] car;
  int r;

  initial begin
    reset = 1; call_btn = '0; cur_floor = 8'h01; complete = 0; hold = 0;

    // T1 reset with all buttons pressed
    cycle(1, 8'hFF, 8'h01, 0, 0);
    cycle(1, 8'hFF, 8'h01, 0, 0);
    check("t1_pending", pending, 8'h00);
    check("t1_valid", req_valid, 0);
    check("t1_dir", sched_dir, 1);

    // T2 SCAN up
    cycle(0, 8'h24, 8'h01, 0, 0);
    cycle(0, 8'h00, 8'h01, 0, 0);
    check("t2_first", request_floor, 8'h04);
    cycle(0, 8'h00, 8'h04, 1, 0);
    cycle(0, 8'h00, 8'h04, 0, 0);
    cycle(0, 8'h00, 8'h04, 0, 0);
    check("t2_second", request_floor, 8'h20);
    cycle(0, 8'h00, 8'h20, 1, 0);
    check("t2_pending", pending, 8'h00);
    check("t2_valid", req_valid, 0);
    idle(8'h20, 1);

    // T3 reversal
    cycle(0, 8'h0A, 8'h40, 0, 0);
    cycle(0, 8'h00, 8'h40, 0, 0);
    check("t3_first", request_floor, 8'h08);
    check("t3_dir", sched_dir, 0);
    cycle(0, 8'h00, 8'h08, 1, 0);
    idle(8'h08, 1);
    cycle(0, 8'h00, 8'h08, 0, 0);
    check("t3_second", request_floor, 8'h02);
    check("t3_dir_kept", sched_dir, 0);
    cycle(0, 8'h00, 8'h02, 1, 0);
    idle(8'h02, 1);

    // T4 hold
    cycle(0, 8'h10, 8'h02, 0, 1);
    for (int i = 0; i < 5; i++) begin
      cycle(0, 8'h00, 8'h02, 0, 1);
      check("t4_held", req_valid, 0);
    end
    cycle(0, 8'h00, 8'h02, 0, 0);
    check("t4_issue", request_floor, 8'h10);
    cycle(0, 8'h00, 8'h10, 1, 0);
    idle(8'h10, 1);

    // T5 same-floor call racing complete
    cycle(0, 8'h04, 8'h10, 0, 0);
    cycle(0, 8'h00, 8'h10, 0, 0);
    check("t5_issue", request_floor, 8'h04);
    cycle(0, 8'h84, 8'h04, 1, 0);
    check("t5_pending", pending, 8'h80);
    idle(8'h04, 2);
    check("t5_next", request_floor, 8'h80);
    cycle(0, 8'h00, 8'h80, 1, 0);
    idle(8'h80, 1);

    // T6 reset mid-BUSY, then invalid car positions
    cycle(0, 8'h01, 8'h80, 0, 0);
    cycle(0, 8'h00, 8'h80, 0, 0);
    check("t6_busy", req_valid, 1);
    cycle(1, 8'h00, 8'h80, 0, 0);
    check("t6_rst_req", request_floor, 8'h00);
    check("t6_rst_pending", pending, 8'h00);
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h08, 8'h00, 0, 0);
      check("t6_cur_zero", req_valid, 0);
    end
    for (int i = 0; i < 3; i++) begin
      cycle(0, 8'h00, 8'h03, 0, 0);
      check("t6_cur_multi", req_valid, 0);
    end
    cycle(0, 8'h00, 8'h01, 0, 0);
    check("t6_recover", request_floor, 8'h08);
    cycle(0, 8'h00, 8'h08, 1, 0);
    idle(8'h08, 1);

    // Randomized traffic
    car = 8'h08;
    for (int i = 0; i < 1500; i++) begin
      logic [N-1:0] call, cur;
      logic cmp, hld, rst;
      r    = $urandom_range(0, 99);
      call = (r < 25) ? N'($urandom_range(1, 255)) : '0;
      hld  = ($urandom_range(0, 99) < 12);
      rst  = ($urandom_range(0, 299) == 0);
      cmp  = 0;
      if ($urandom_range(0, 99) < 30) begin
        cmp = 1;
        if (m_busy) car = N'(1) << m_tgt;
      end
      if ($urandom_range(0, 99) < 10) car = N'(1) << $urandom_range(0, N - 1);
      cur = ($urandom_range(0, 99) < 8) ? N'($urandom_range(0, 255)) : car;
      cycle(rst, call, cur, cmp, hld);
    end

    check("exp_q_empty", exp_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
